// File: rtl/cofre_pkg.sv
// cofre_pkg: shared state encoding and width helper for the safe controller
// Contents:
//   estado_t  - controller state encoding (VAZIO, FECHADO, ABERTO, BLOQUEADO)
//   clog2     - bits needed to count 0..n-1, never less than 1
package cofre_pkg;
   typedef enum logic [1:0] {
      VAZIO     = 2'd0,
      FECHADO   = 2'd1,
      ABERTO    = 2'd2,
      BLOQUEADO = 2'd3
   } estado_t;
   // Never returns 0, so a one-cycle lockout still gets a real timer bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/cofre_dif_mag.sv
// cofre_dif_mag: combinational magnitude/sign comparator for two unsigned words
// Ports:
//   a, b   in  WIDTH  unsigned operands
//   mag    out WIDTH  |a - b|
//   neg    out 1      a < b (borrow of the WIDTH+1-bit subtraction)
//   igual  out 1      a == b
module cofre_dif_mag
   import cofre_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] mag,
   output logic             neg,
   output logic             igual
);
   logic [WIDTH:0] d;
   assign d     = {1'b0, a} - {1'b0, b};
   assign neg   = d[WIDTH];
   // |a-b| <= 2^WIDTH-1, so negating the low bits never overflows
   assign mag   = neg ? WIDTH'(0) - d[WIDTH-1:0] : d[WIDTH-1:0];
   assign igual = (a == b);
endmodule

// File: rtl/cofre_controlador.sv
// cofre_controlador: digital safe controller with stored password, attempt count and lockout
// Ports:
//   clock       in  1      system clock, rising edge
//   reset       in  1      synchronous active-high reset
//   senha_in    in  WIDTH  password on the switches
//   cadastrar   in  1      strobe: store senha_in (only when empty or open)
//   confirmar   in  1      strobe: check senha_in against the stored password
//   trancar     in  1      strobe: close an open safe
//   diferenca   out WIDTH  |senha_in - senha_salva| at the last check
//   ponto       out 1      last checked password was below the stored one
//   tentativas  out 4      failed attempts since last success or unlock
//   led_verme   out 1      error flag set or locked out
//   led_azu     out 1      empty or closed with no error
//   led_verd    out 1      open
module cofre_controlador
   import cofre_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int MAX_TENT    = 3,
   parameter int LOCK_CYCLES = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] senha_in,
   input  logic             cadastrar,
   input  logic             confirmar,
   input  logic             trancar,
   output logic [WIDTH-1:0] diferenca,
   output logic             ponto,
   output logic [3:0]       tentativas,
   output logic             led_verme,
   output logic             led_azu,
   output logic             led_verd
);
   localparam int TW = clog2(LOCK_CYCLES);
   estado_t          estado, estado_n;
   logic             erro, erro_n;
   logic [WIDTH-1:0] senha_salva;
   logic [TW-1:0]    timer;
   logic [WIDTH-1:0] mag;
   logic             neg, igual;
   logic [3:0]       tent_prox;
   logic             falha_max, checa, fim_bloq;
   cofre_dif_mag #(.WIDTH(WIDTH)) u_dif (
      .a     (senha_in),
      .b     (senha_salva),
      .mag   (mag),
      .neg   (neg),
      .igual (igual)
   );
   assign checa     = (estado == FECHADO) && confirmar;
   assign fim_bloq  = (estado == BLOQUEADO) && (timer == '0);
   assign tent_prox = (tentativas >= 4'(MAX_TENT)) ? tentativas : tentativas + 4'd1;
   assign falha_max = (tent_prox == 4'(MAX_TENT));
   always_comb begin
      estado_n = estado;
      erro_n   = erro;
      case (estado)
         VAZIO:     estado_n = cadastrar ? FECHADO : VAZIO;
         FECHADO:   if (confirmar) begin
                       estado_n = igual ? ABERTO : (falha_max ? BLOQUEADO : FECHADO);
                       erro_n   = !igual;
                    end
         // cadastrar wins over a simultaneous trancar/confirmar
         ABERTO:    estado_n = (!cadastrar && (trancar || confirmar)) ? FECHADO : ABERTO;
         BLOQUEADO: estado_n = (timer == '0) ? FECHADO : BLOQUEADO;
         default:   estado_n = VAZIO;
      endcase
   end
   // LEDs are registered from the next-state values so they line up with estado.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado      <= VAZIO;
         erro        <= 1'b0;
         senha_salva <= '0;
         diferenca   <= '0;
         ponto       <= 1'b0;
         tentativas  <= 4'd0;
         timer       <= '0;
         led_verme   <= 1'b0;
         led_azu     <= 1'b1;
         led_verd    <= 1'b0;
      end else begin
         estado    <= estado_n;
         erro      <= erro_n;
         led_verd  <= (estado_n == ABERTO);
         led_verme <= erro_n || (estado_n == BLOQUEADO);
         led_azu   <= !erro_n && ((estado_n == VAZIO) || (estado_n == FECHADO));
         if (cadastrar && ((estado == VAZIO) || (estado == ABERTO)))
            senha_salva <= senha_in;
         if (checa) begin
            diferenca  <= mag;
            ponto      <= neg;
            tentativas <= igual ? 4'd0 : tent_prox;
         end
         if (fim_bloq)
            tentativas <= 4'd0;
         // Loaded with LOCK_CYCLES-1 so that the count down to 0 spans LOCK_CYCLES cycles.
         if (checa && !igual && falha_max)
            timer <= TW'(LOCK_CYCLES - 1);
         else if ((estado == BLOQUEADO) && (timer != '0))
            timer <= timer - 1'b1;
      end
   end
endmodule

// File: tb/tb_cofre_controlador.sv
// tb_cofre_controlador: randomized self-checking bench with a behavioural safe model
module tb_cofre_controlador;
   localparam int W    = 4;
   localparam int MAXT = 3;
   localparam int LOCK = 16;
   logic         clock = 0;
   logic         reset = 0;
   logic [W-1:0] senha_in = '0;
   logic         cadastrar = 0, confirmar = 0, trancar = 0;
   logic [W-1:0] diferenca;
   logic         ponto;
   logic [3:0]   tentativas;
   logic         led_verme, led_azu, led_verd;
   logic [11:0]  actv;
   int nchk = 0, nerr = 0;
   // model: password presence, open flag, remaining lockout cycles, error flag
   bit m_tem, m_open, m_erro, m_pt;
   int m_lock, m_salva, m_dif, m_tent;
   cofre_controlador #(.WIDTH(W), .MAX_TENT(MAXT), .LOCK_CYCLES(LOCK)) dut (
      .clock      (clock),
      .reset      (reset),
      .senha_in   (senha_in),
      .cadastrar  (cadastrar),
      .confirmar  (confirmar),
      .trancar    (trancar),
      .diferenca  (diferenca),
      .ponto      (ponto),
      .tentativas (tentativas),
      .led_verme  (led_verme),
      .led_azu    (led_azu),
      .led_verd   (led_verd)
   );
   always #5 clock = ~clock;
   assign actv = {diferenca, ponto, tentativas, led_verme, led_azu, led_verd};
   function automatic logic [11:0] expv();
      logic verme, verd;
      verme = m_erro || (m_lock > 0);
      verd  = m_open;
      return {4'(m_dif), m_pt, 4'(m_tent), verme, !verme && !verd, verd};
   endfunction
   task automatic model(input int s, input bit cad, cf, tr, rs);
      int d;
      if (rs) begin
         m_tem = 0; m_open = 0; m_erro = 0; m_pt = 0;
         m_lock = 0; m_salva = 0; m_dif = 0; m_tent = 0;
      end else if (m_lock > 0) begin
         m_lock--;
         if (m_lock == 0) m_tent = 0;
      end else if (!m_tem) begin
         if (cad) begin m_salva = s; m_tem = 1; end
      end else if (m_open) begin
         if (cad) m_salva = s;
         else if (tr || cf) m_open = 0;
      end else if (cf) begin
         d = s - m_salva;
         m_dif = (d < 0) ? -d : d;
         m_pt = (d < 0);
         if (d == 0) begin
            m_open = 1; m_tent = 0; m_erro = 0;
         end else begin
            m_erro = 1;
            m_tent = (m_tent + 1 > MAXT) ? MAXT : m_tent + 1;
            if (m_tent == MAXT) m_lock = LOCK;
         end
      end
   endtask
   task automatic step(input logic [W-1:0] s, input bit cad, cf, tr, rs);
      @(negedge clock);
      senha_in = s; cadastrar = cad; confirmar = cf; trancar = tr; reset = rs;
      @(posedge clock);
      model(int'(s), cad, cf, tr, rs);
      #1;
      cadastrar = 0; confirmar = 0; trancar = 0; reset = 0;
   endtask
   task automatic test_reset();
      step('0, 0, 0, 0, 1);
      nchk++;
      if (actv !== 12'h002) begin
         nerr++; $display("FAIL reset_values: got %h expected %h", actv, 12'h002);
      end
      step(4'h7, 0, 1, 1, 0);
      nchk++;
      if (actv !== expv()) begin
         nerr++; $display("FAIL vazio_ignores: got %h expected %h", actv, expv());
      end
   endtask
   task automatic test_basic();
      step(4'h9, 1, 0, 0, 0);
      nchk++;
      if (led_azu !== 1'b1 || tentativas !== 4'd0 || actv !== expv()) begin
         nerr++; $display("FAIL store_9: got %h expected %h", actv, expv());
      end
      step(4'h9, 1, 0, 0, 0);
      step(4'h9, 0, 1, 0, 0);
      nchk++;
      if ({led_verd, diferenca, ponto} !== {1'b1, 4'h0, 1'b0} || actv !== expv()) begin
         nerr++; $display("FAIL open_9: got %h expected %h", actv, expv());
      end
      step(4'h9, 0, 0, 1, 0);
      nchk++;
      if (led_azu !== 1'b1 || actv !== expv()) begin
         nerr++; $display("FAIL close: got %h expected %h", actv, expv());
      end
      step(4'h3, 0, 1, 0, 0);
      nchk++;
      if ({diferenca, ponto, tentativas, led_verme} !== {4'd6, 1'b1, 4'd1, 1'b1} || actv !== expv()) begin
         nerr++; $display("FAIL wrong_3: got %h expected %h", actv, expv());
      end
      step(4'hC, 0, 1, 0, 0);
      nchk++;
      if ({diferenca, ponto, tentativas} !== {4'd3, 1'b0, 4'd2} || actv !== expv()) begin
         nerr++; $display("FAIL wrong_c: got %h expected %h", actv, expv());
      end
   endtask
   task automatic test_lockout();
      step(4'h0, 0, 1, 0, 0);
      nchk++;
      if (tentativas !== 4'd3 || led_verme !== 1'b1 || actv !== expv()) begin
         nerr++; $display("FAIL lock_entry: got %h expected %h", actv, expv());
      end
      for (int i = 1; i < LOCK; i++) begin
         step(4'h9, 1'($urandom), 1'($urandom), 1'($urandom), 0);
         nchk++;
         if (tentativas !== 4'd3 || led_verme !== 1'b1 || actv !== expv()) begin
            nerr++; $display("FAIL lock_hold[%0d]: got %h expected %h", i, actv, expv());
         end
      end
      step(4'h9, 0, 0, 0, 0);
      nchk++;
      if (tentativas !== 4'd0 || led_verme !== 1'b1 || actv !== expv()) begin
         nerr++; $display("FAIL lock_release: got %h expected %h", actv, expv());
      end
      step(4'h9, 0, 1, 0, 0);
      nchk++;
      if (led_verd !== 1'b1 || actv !== expv()) begin
         nerr++; $display("FAIL open_after_lock: got %h expected %h", actv, expv());
      end
   endtask
   task automatic test_cad_priority();
      step(4'h5, 1, 0, 1, 0);
      nchk++;
      if (led_verd !== 1'b1 || actv !== expv()) begin
         nerr++; $display("FAIL cad_over_trancar: got %h expected %h", actv, expv());
      end
      step(4'h5, 0, 0, 1, 0);
      step(4'h5, 0, 1, 0, 0);
      nchk++;
      if (led_verd !== 1'b1 || diferenca !== 4'd0 || actv !== expv()) begin
         nerr++; $display("FAIL open_new_5: got %h expected %h", actv, expv());
      end
   endtask
   task automatic test_reset_in_lock();
      step(4'h5, 0, 0, 1, 0);
      for (int i = 0; i < MAXT; i++) step(4'hF, 0, 1, 0, 0);
      step(4'h5, 0, 0, 0, 0);
      nchk++;
      if (tentativas !== 4'd3 || actv !== expv()) begin
         nerr++; $display("FAIL locked_before_reset: got %h expected %h", actv, expv());
      end
      step(4'h5, 0, 0, 0, 1);
      step(4'h5, 0, 1, 0, 0);
      nchk++;
      if (actv !== 12'h002 || actv !== expv()) begin
         nerr++; $display("FAIL reset_in_lock: got %h expected %h", actv, 12'h002);
      end
   endtask
   task automatic test_random();
      logic [W-1:0] s;
      for (int i = 0; i < 400; i++) begin
         s = ($urandom_range(1) == 1) ? W'(m_salva) : W'($urandom);
         step(s, $urandom_range(3) == 0, $urandom_range(2) == 0,
              $urandom_range(3) == 0, $urandom_range(60) == 0);
         nchk++;
         if (actv !== expv()) begin
            nerr++; $display("FAIL random[%0d]: got %h expected %h", i, actv, expv());
         end
      end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_lockout();
      test_cad_priority();
      test_reset_in_lock();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
